id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock for every register in the block.
REQ-002 SHALL have port Reset, input, 1; reset is synchronous and active-high, sampled on the rising edge of Clk.
REQ-003 SHALL have port IF_ID_Instr, input, 32: instruction held in the IF/ID register.
REQ-004 SHALL have port IF_ID_PC4, input, 32: PC+4 of that instruction.
REQ-005 SHALL have port IF_ID_Valid, input, 1: IF/ID holds a real instruction.
REQ-006 SHALL have port Flush, input, 1: EX resolved a taken branch, so the ID instruction is wrong-path.
REQ-007 SHALL have ports PR1 and PR2, output, 5 each: register-file read addresses; PR1=Instr[25:21] (rs), PR2=Instr[20:16] (rt); both combinational.
REQ-008 SHALL have ports RD1 and RD2, input, 32 each: register-file combinational read data.
REQ-009 SHALL have ports WB_Write (in, 1), WB_WR (in, 5) and WB_WD (in, 32): the same write-back triple that drives the register file.
REQ-010 SHALL have port Stall, output, 1, combinational: hold PC and IF/ID this cycle.
REQ-011 SHALL have the following registered ID/EX outputs:
- ID_EX_Valid (1)
- ID_EX_A and ID_EX_B (32 each)
- ID_EX_Imm (32)
- ID_EX_PC4 (32)
- ID_EX_Rs, ID_EX_Rt and ID_EX_Dest (5 each)
- ID_EX_Funct (6)
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch and ID_EX_ALUSrc (1 each)
- ID_EX_ALUOp (2)

Function
REQ-012 SHALL decode opcodes as follows (ALUOp: 10=funct, 00=add, 01=sub):
- 0x00 R-type: RegWrite=1, Dest=rd, ALUOp=10.
- 0x23 lw: RegWrite=1, MemRead=1, ALUSrc=1, Dest=rt, ALUOp=00.
- 0x2B sw: MemWrite=1, ALUSrc=1, ALUOp=00.
- 0x04 beq: Branch=1, ALUOp=01.
- 0x08 addi: RegWrite=1, ALUSrc=1, Dest=rt, ALUOp=00.
REQ-013 SHALL treat any other opcode as a NOP: all control bits 0 and Valid=1.
REQ-014 SHALL form Imm as the sign extension of Instr[15:0] to 32 bits, and Funct as Instr[5:0].
REQ-015 SHALL bypass write-back to the operands: A = WB_WD when WB_Write=1, WB_WR!=0 and WB_WR==rs; otherwise A = RD1.
REQ-016 SHALL apply the same bypass rule to B, comparing WB_WR against rt and falling back to RD2. This covers the register file's same-cycle write/read returning the stale value.
REQ-017 SHALL produce A and B as 0 for register 0 regardless of the WB inputs.
REQ-018 SHALL detect a load-use hazard when all of the following hold:
- ID_EX_Valid=1 and ID_EX_MemRead=1 and ID_EX_Dest!=0;
- IF_ID_Valid=1;
- ID_EX_Dest==rs, or ID_EX_Dest==rt with the ID opcode being R-type, sw or beq.
REQ-019 SHALL assert Stall = hazard AND NOT Flush.
REQ-020 SHALL load a bubble into ID/EX on the next edge when Stall=1: Valid=0 and all control bits 0; data fields are don't-care but SHALL be zeroed.
REQ-021 SHALL load a bubble on the next edge when Flush=1, and Flush SHALL take priority over Stall.
REQ-022 SHALL load a bubble on the next edge when IF_ID_Valid=0.
REQ-023 SHALL otherwise load the decoded instruction with Valid=1, giving a latency of one cycle from IF/ID to ID/EX.
REQ-024 SHALL guarantee that a stall lasts exactly one cycle: the bubble clears ID_EX_MemRead, so the hazard deasserts on the following cycle.
REQ-025 SHALL treat a bubble, however caused, as forcing RegWrite, MemRead, MemWrite and Branch to 0 so that no architectural side effect occurs.

Reset
REQ-026 SHALL clear every ID/EX register to 0 on a rising Clk edge with Reset=1, including ID_EX_Valid=0.
REQ-027 SHALL give Reset priority over Flush, Stall and normal load.
REQ-028 SHALL make Stall 0 in the cycle after reset, because it is derived from cleared state.
REQ-029 SHALL discard any in-flight instruction when Reset is asserted mid-operation; no partial state remains.

Verification
REQ-030 SHALL verify decode of addi: rf[1]=5 and IF_ID_Instr=addi $2,$1,-3 (0x2022FFFD) -> next cycle A=5, Imm=0xFFFFFFFD, Dest=2, RegWrite=1, ALUSrc=1, Valid=1.
REQ-031 SHALL verify the WB bypass: WB_Write=1, WB_WR=3, WB_WD=0xDEADBEEF, rf[3] stale=0, and ID holds add $4,$3,$3 -> next cycle A=B=0xDEADBEEF.
REQ-032 SHALL verify that register 0 is never bypassed: WB_Write=1, WB_WR=0, WB_WD=0x1234, and ID reads rs=0 -> A=0.
REQ-033 SHALL verify load-use stall: lw $5,0($1) in EX and add $6,$5,$2 in ID -> Stall=1 for exactly one cycle, then a bubble (Valid=0, RegWrite=0), then the add issues with Valid=1.
REQ-034 SHALL verify Flush over Stall: the same hazard as REQ-033 with Flush=1 -> Stall=0 and next ID_EX_Valid=0.
REQ-035 SHALL verify reset mid-stream: Reset=1 for one edge while a valid lw is in ID/EX -> all outputs 0, Stall=0 on the following cycle.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: control decode, operand read with write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IF_ID_Instr,
   input  logic [31:0] IF_ID_PC4,
   input  logic        IF_ID_Valid,
   input  logic        Flush,
   output logic [4:0]  PR1,
   output logic [4:0]  PR2,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   input  logic        WB_Write,
   input  logic [4:0]  WB_WR,
   input  logic [31:0] WB_WD,
   output logic        Stall,
   output logic        ID_EX_Valid,
   output logic [31:0] ID_EX_A,
   output logic [31:0] ID_EX_B,
   output logic [31:0] ID_EX_Imm,
   output logic [31:0] ID_EX_PC4,
   output logic [4:0]  ID_EX_Rs,
   output logic [4:0]  ID_EX_Rt,
   output logic [4:0]  ID_EX_Dest,
   output logic [5:0]  ID_EX_Funct,
   output logic        ID_EX_RegWrite,
   output logic        ID_EX_MemRead,
   output logic        ID_EX_MemWrite,
   output logic        ID_EX_Branch,
   output logic        ID_EX_ALUSrc,
   output logic [1:0]  ID_EX_ALUOp
);

   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddi  = 6'h08;

   typedef struct packed {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [5:0]  funct;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic [1:0]  alu_op;
   } idex_t;

   idex_t idex_d, idex_q;

   logic [5:0] opcode;
   logic [4:0] rs, rt, rd;
   logic       uses_rt;
   logic       hazard;
   logic       bubble;

   assign opcode = IF_ID_Instr[31:26];
   assign rs     = IF_ID_Instr[25:21];
   assign rt     = IF_ID_Instr[20:16];
   assign rd     = IF_ID_Instr[15:11];
   assign PR1    = rs;
   assign PR2    = rt;

   // rt is a source operand only for R-type, sw and beq; for lw/addi it is the destination.
   assign uses_rt = (opcode == OpRType) || (opcode == OpSw) || (opcode == OpBeq);

   assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0) && IF_ID_Valid &&
                   ((idex_q.dest == rs) || ((idex_q.dest == rt) && uses_rt));

   assign Stall  = hazard && !Flush;
   assign bubble = Flush || Stall || !IF_ID_Valid;

   always_comb begin
      idex_d = '0;
      if (!bubble) begin
         idex_d.valid = 1'b1;
         // Register 0 reads as zero and is never bypassed.
         if (rs == 5'd0)                     idex_d.a = 32'd0;
         else if (WB_Write && (WB_WR == rs)) idex_d.a = WB_WD;
         else                                idex_d.a = RD1;
         if (rt == 5'd0)                     idex_d.b = 32'd0;
         else if (WB_Write && (WB_WR == rt)) idex_d.b = WB_WD;
         else                                idex_d.b = RD2;
         idex_d.imm   = {{16{IF_ID_Instr[15]}}, IF_ID_Instr[15:0]};
         idex_d.pc4   = IF_ID_PC4;
         idex_d.rs    = rs;
         idex_d.rt    = rt;
         idex_d.funct = IF_ID_Instr[5:0];
         case (opcode)
            OpRType: begin
               idex_d.reg_write = 1'b1;
               idex_d.dest      = rd;
               idex_d.alu_op    = 2'b10;
            end
            OpLw: begin
               idex_d.reg_write = 1'b1;
               idex_d.mem_read  = 1'b1;
               idex_d.alu_src   = 1'b1;
               idex_d.dest      = rt;
            end
            OpSw: begin
               idex_d.mem_write = 1'b1;
               idex_d.alu_src   = 1'b1;
            end
            OpBeq: begin
               idex_d.branch = 1'b1;
               idex_d.alu_op = 2'b01;
            end
            OpAddi: begin
               idex_d.reg_write = 1'b1;
               idex_d.alu_src   = 1'b1;
               idex_d.dest      = rt;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) idex_q <= '0;
      else       idex_q <= idex_d;
   end

   assign ID_EX_Valid    = idex_q.valid;
   assign ID_EX_A        = idex_q.a;
   assign ID_EX_B        = idex_q.b;
   assign ID_EX_Imm      = idex_q.imm;
   assign ID_EX_PC4      = idex_q.pc4;
   assign ID_EX_Rs       = idex_q.rs;
   assign ID_EX_Rt       = idex_q.rt;
   assign ID_EX_Dest     = idex_q.dest;
   assign ID_EX_Funct    = idex_q.funct;
   assign ID_EX_RegWrite = idex_q.reg_write;
   assign ID_EX_MemRead  = idex_q.mem_read;
   assign ID_EX_MemWrite = idex_q.mem_write;
   assign ID_EX_Branch   = idex_q.branch;
   assign ID_EX_ALUSrc   = idex_q.alu_src;
   assign ID_EX_ALUOp    = idex_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with a small register-file model driving RD1/RD2.
module tb_id_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] IF_ID_Instr, IF_ID_PC4;
   logic        IF_ID_Valid, Flush;
   logic [4:0]  PR1, PR2;
   logic [31:0] RD1, RD2;
   logic        WB_Write;
   logic [4:0]  WB_WR;
   logic [31:0] WB_WD;
   logic        Stall;
   logic        ID_EX_Valid;
   logic [31:0] ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_PC4;
   logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Dest;
   logic [5:0]  ID_EX_Funct;
   logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUSrc;
   logic [1:0]  ID_EX_ALUOp;

   logic [31:0] rf [32];
   int total = 0;
   int bad   = 0;

   assign RD1 = rf[PR1];
   assign RD2 = rf[PR2];

   always #5 Clk = ~Clk;

   id_stage dut (
      .Clk(Clk), .Reset(Reset), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
      .IF_ID_Valid(IF_ID_Valid), .Flush(Flush), .PR1(PR1), .PR2(PR2), .RD1(RD1), .RD2(RD2),
      .WB_Write(WB_Write), .WB_WR(WB_WR), .WB_WD(WB_WD), .Stall(Stall),
      .ID_EX_Valid(ID_EX_Valid), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm),
      .ID_EX_PC4(ID_EX_PC4), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Dest(ID_EX_Dest),
      .ID_EX_Funct(ID_EX_Funct), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUSrc(ID_EX_ALUSrc),
      .ID_EX_ALUOp(ID_EX_ALUOp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Control bits packed as {Valid, RegWrite, MemRead, MemWrite, Branch, ALUSrc, ALUOp}.
   function automatic logic [31:0] ctrl();
      return {24'd0, ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
              ID_EX_Branch, ID_EX_ALUSrc, ID_EX_ALUOp};
   endfunction

   function automatic logic [31:0] all_or();
      return ID_EX_A | ID_EX_B | ID_EX_Imm | ID_EX_PC4 | {27'd0, ID_EX_Rs | ID_EX_Rt | ID_EX_Dest}
             | {26'd0, ID_EX_Funct} | ctrl();
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      rf[0] = 32'h55;   // nonzero model value: reg 0 must still read as 0
      rf[1] = 32'd5;
      rf[3] = 32'd0;
      Reset = 1'b1; IF_ID_Instr = 32'h8C250000; IF_ID_PC4 = 32'h0000_0100;
      IF_ID_Valid = 1'b1; Flush = 1'b0; WB_Write = 1'b0; WB_WR = 5'd0; WB_WD = 32'd0;
      tick();
      check("reset_all_zero", all_or(), 32'd0);
      check("reset_stall", {31'd0, Stall}, 32'd0);
      Reset = 1'b0;

      // addi $2,$1,-3
      IF_ID_Instr = 32'h2022FFFD; IF_ID_PC4 = 32'h0000_0104;
      #1;
      check("addi_pr1", {27'd0, PR1}, 32'd1);
      check("addi_pr2", {27'd0, PR2}, 32'd2);
      tick();
      check("addi_a", ID_EX_A, 32'd5);
      check("addi_imm", ID_EX_Imm, 32'hFFFFFFFD);
      check("addi_dest", {27'd0, ID_EX_Dest}, 32'd2);
      check("addi_ctrl", ctrl(), 32'b1_1_0_0_0_1_00);
      check("addi_pc4", ID_EX_PC4, 32'h0000_0104);

      // add $4,$3,$3 with write-back of $3 in the same cycle
      IF_ID_Instr = 32'h00632020; WB_Write = 1'b1; WB_WR = 5'd3; WB_WD = 32'hDEADBEEF;
      tick();
      check("byp_a", ID_EX_A, 32'hDEADBEEF);
      check("byp_b", ID_EX_B, 32'hDEADBEEF);
      check("rtype_ctrl", ctrl(), 32'b1_1_0_0_0_0_10);
      check("rtype_dest", {27'd0, ID_EX_Dest}, 32'd4);
      check("rtype_funct", {26'd0, ID_EX_Funct}, 32'h20);

      // add $7,$0,$0 with write-back targeting $0
      IF_ID_Instr = 32'h00003820; WB_WR = 5'd0; WB_WD = 32'h1234;
      tick();
      check("r0_a", ID_EX_A, 32'd0);
      check("r0_b", ID_EX_B, 32'd0);
      WB_Write = 1'b0;

      // lw $5,0($1) then add $6,$5,$2
      IF_ID_Instr = 32'h8C250000;
      tick();
      check("lw_ctrl", ctrl(), 32'b1_1_1_0_0_1_00);
      check("lw_dest", {27'd0, ID_EX_Dest}, 32'd5);
      IF_ID_Instr = 32'h00A23020;
      #1;
      check("lu_stall", {31'd0, Stall}, 32'd1);
      tick();
      check("lu_bubble", ctrl(), 32'd0);
      check("lu_stall_drop", {31'd0, Stall}, 32'd0);
      tick();
      check("lu_issue", ctrl(), 32'b1_1_0_0_0_0_10);
      check("lu_issue_dest", {27'd0, ID_EX_Dest}, 32'd6);

      // rt of lw/addi is a destination, not a source; for sw it is a source
      IF_ID_Instr = 32'h8C250000;
      tick();
      IF_ID_Instr = 32'h20250001;   // addi $5,$1,1
      #1;
      check("addi_rt_nohaz", {31'd0, Stall}, 32'd0);
      IF_ID_Instr = 32'hAC250000;   // sw $5,0($1)
      #1;
      check("sw_rt_haz", {31'd0, Stall}, 32'd1);
      Flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, Stall}, 32'd0);
      tick();
      check("flush_bubble", ctrl(), 32'd0);
      Flush = 1'b0;

      // sw and beq decode
      tick();
      check("sw_ctrl", ctrl(), 32'b1_0_0_1_0_1_00);
      IF_ID_Instr = 32'h10220008;   // beq $1,$2,8
      tick();
      check("beq_ctrl", ctrl(), 32'b1_0_0_0_1_0_01);

      // unknown opcode is a valid NOP
      IF_ID_Instr = 32'hFC221234;
      tick();
      check("nop_ctrl", ctrl(), 32'b1_0_0_0_0_0_00);

      IF_ID_Valid = 1'b0;
      tick();
      check("invalid_bubble", ctrl(), 32'd0);
      IF_ID_Valid = 1'b1;

      // reset while lw sits in ID/EX and a dependent add waits in ID
      IF_ID_Instr = 32'h8C250000;
      tick();
      check("pre_reset_valid", {31'd0, ID_EX_Valid}, 32'd1);
      IF_ID_Instr = 32'h00A23020;
      Reset = 1'b1;
      tick();
      check("midreset_zero", all_or(), 32'd0);
      check("midreset_stall", {31'd0, Stall}, 32'd0);
      Reset = 1'b0;
      #1;
      check("postreset_stall", {31'd0, Stall}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
